// File: rtl/alu_cmd_master.sv
// rtl/alu_cmd_master.sv - UART command master: sends op_a, op_b, opcode, then reads back one result byte
// Optional feature: define ALU_CMD_TIMEOUT_EN to build the result-wait timeout.
module alu_cmd_master #(
  parameter int NBIT    = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [NBIT-1:0] op_a,
  input  logic [NBIT-1:0] op_b,
  input  logic [NBIT-1:0] opcode,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [NBIT-1:0] w_data,
  input  logic            rx_empty,
  input  logic [NBIT-1:0] r_data,
  output logic            rd_uart,
  output logic [NBIT-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_A   = 3'd1;
  localparam logic [2:0] S_SEND_B   = 3'd2;
  localparam logic [2:0] S_SEND_OP  = 3'd3;
  localparam logic [2:0] S_WAIT_RES = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]      state;
  logic [NBIT-1:0] a_q;
  logic [NBIT-1:0] b_q;
  logic [NBIT-1:0] op_q;
  logic            tmo_hit;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] tmo_cnt;
  logic          tmo_err_q;

  // Fires on the last allowed WAIT_RES cycle when still no result byte is available.
  assign tmo_hit     = (state == S_WAIT_RES) && rx_empty && (tmo_cnt == CW'(TIMEOUT - 1));
  assign timeout_err = tmo_err_q;

  // Timeout counter restarts when the opcode byte goes out; sticky error cleared by a new start.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == S_SEND_OP && !tx_full) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT_RES) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == S_IDLE && start) begin
        tmo_err_q <= 1'b0;
      end else if (tmo_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  // No counter without the timeout feature; WAIT_RES waits for as long as it takes.
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Transaction sequencer and captured operand / result registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            op_q  <= opcode;
            state <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (!tx_full) state <= S_SEND_B;
        end
        S_SEND_B: begin
          if (!tx_full) state <= S_SEND_OP;
        end
        S_SEND_OP: begin
          if (!tx_full) state <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (!rx_empty) begin
            result <= r_data;
            state  <= S_DONE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO strobes are decoded from state so they drop the instant the FIFO flags or reset say so.
  always_comb begin
    wr_uart = 1'b0;
    w_data  = '0;
    rd_uart = 1'b0;
    case (state)
      S_SEND_A: begin
        wr_uart = !tx_full;
        w_data  = tx_full ? '0 : a_q;
      end
      S_SEND_B: begin
        wr_uart = !tx_full;
        w_data  = tx_full ? '0 : b_q;
      end
      S_SEND_OP: begin
        wr_uart = !tx_full;
        w_data  = tx_full ? '0 : op_q;
      end
      S_WAIT_RES: begin
        rd_uart = !rx_empty;
      end
      default: begin
        wr_uart = 1'b0;
      end
    endcase
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_master.sv
// tb/tb_alu_cmd_master.sv - directed, table-driven bench for alu_cmd_master
module tb_alu_cmd_master;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic [7:0] opcode = '0;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = '0;
  logic       rd_uart;
  logic [7:0] result;
  logic       done;
  logic       busy;
  logic       timeout_err;

  alu_cmd_master #(.NBIT(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .rx_empty(rx_empty),
    .r_data(r_data), .rd_uart(rd_uart), .result(result), .done(done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] rx;
  } vec_t;

  int         total = 0;
  int         passed = 0;
  logic [7:0] tx_log[$];
  int         rd_count = 0;
  int         done_count = 0;
  int         viol_full = 0;
  int         viol_wdata = 0;
  int         viol_rd = 0;

  // Passive FIFO-side monitor sampled mid-cycle.
  always @(negedge CLK) begin
    if (wr_uart) tx_log.push_back(w_data);
    if (rd_uart) rd_count++;
    if (done) done_count++;
    if (wr_uart && tx_full) viol_full++;
    if (!wr_uart && w_data != 8'h00) viol_wdata++;
    if (rd_uart && rx_empty) viol_rd++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    rd_count   = 0;
    done_count = 0;
  endtask

  // Steps cycles until done; lat is the cycle index (accept edge starts cycle 1), 0 on budget expiry.
  task automatic wait_done(input int first, output int lat);
    logic pop;
    pop = 1'b0;
    lat = 0;
    for (int n = first; n < first + 80; n++) begin
      if (pop) rx_empty = 1'b1;
      #1;
      if (done) begin
        lat = n;
        break;
      end
      pop = rd_uart;
      tick();
    end
    tick();
  endtask

  task automatic check_bytes(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op);
    chk({name, "_nbytes"}, tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk({name, "_byte_a"}, tx_log[0], a);
      chk({name, "_byte_b"}, tx_log[1], b);
      chk({name, "_byte_op"}, tx_log[2], op);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    clear_logs();
    op_a = v.a; op_b = v.b; opcode = v.op;
    rx_empty = 1'b0; r_data = v.rx;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a = ~v.a; op_b = ~v.b; opcode = ~v.op;
    wait_done(1, lat);
    chk({nm, "_latency"}, lat, 5);
    check_bytes(nm, v.a, v.b, v.op);
    chk({nm, "_rd_count"}, rd_count, 1);
    chk({nm, "_done_count"}, done_count, 1);
    chk({nm, "_result"}, result, v.rx);
    chk({nm, "_busy_end"}, busy, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int lat;
    int stall_wr;
    int busy_cycles;
    logic te_early;

    vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, rx: 8'h08};
    vecs[1] = '{a: 8'hA5, b: 8'h5A, op: 8'h01, rx: 8'hC3};
    vecs[2] = '{a: 8'h00, b: 8'hFF, op: 8'h7E, rx: 8'h00};
    vecs[3] = '{a: 8'h12, b: 8'h34, op: 8'h56, rx: 8'hFF};

    // Reset state
    #12;
    chk("reset_outputs", {23'd0, wr_uart, rd_uart, done, busy, timeout_err, 4'd0}, 0);
    chk("reset_w_data", w_data, 0);
    chk("reset_result", result, 0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // tx_full stall before the op_b write; start pulses in SEND_B and DONE must be ignored
    clear_logs();
    op_a = 8'h11; op_b = 8'h22; opcode = 8'h33; rx_empty = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tx_full = 1'b1;
    op_a = 8'h99; op_b = 8'h88; opcode = 8'h77; start = 1'b1;
    stall_wr = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (wr_uart) stall_wr++;
      tick();
      start = 1'b0;
    end
    chk("stall_no_write", stall_wr, 0);
    chk("stall_busy", busy, 1);
    tx_full = 1'b0;
    tick();
    tick();
    rx_empty = 1'b0; r_data = 8'h44;
    wait_done(14, lat);
    check_bytes("stall", 8'h11, 8'h22, 8'h33);
    chk("stall_result", result, 8'h44);
    chk("stall_done_count", done_count, 1);

    // start held in DONE is ignored
    clear_logs();
    op_a = 8'h01; op_b = 8'h02; opcode = 8'h03; rx_empty = 1'b0; r_data = 8'h06;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1;
    op_a = 8'hE0;
    #1;
    chk("done_state", done, 1);
    tick();
    start = 1'b0;
    rx_empty = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("start_in_done_ignored", busy, 0);
    check_bytes("doneign", 8'h01, 8'h02, 8'h03);

    // Reset in WAIT_RES abandons the transaction; late RX byte must not be popped
    clear_logs();
    op_a = 8'h0A; op_b = 8'h0B; opcode = 8'h0C; rx_empty = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("wait_res_busy", busy, 1);
    RESET = 1'b0;
    #1;
    chk("midreset_outputs", {27'd0, wr_uart, rd_uart, done, busy, timeout_err}, 0);
    chk("midreset_result", result, 0);
    chk("midreset_w_data", w_data, 0);
    rx_empty = 1'b0; r_data = 8'h55;
    tick();
    RESET = 1'b1;
    clear_logs();
    for (int i = 0; i < 6; i++) tick();
    chk("postreset_no_pop", rd_count, 0);
    chk("postreset_no_write", tx_log.size(), 0);
    chk("postreset_result", result, 0);
    chk("postreset_idle", busy, 0);
    rx_empty = 1'b1;

    // Known result before the wait-forever / timeout sequence
    run_vec('{a: 8'h21, b: 8'h43, op: 8'h65, rx: 8'h3C}, 4);
    clear_logs();
    op_a = 8'h07; op_b = 8'h08; opcode = 8'h09; rx_empty = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
    busy_cycles = 0;
    te_early = 1'b0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (!busy) break;
      busy_cycles++;
      te_early = te_early | timeout_err;
      tick();
    end
    chk("tmo_busy_cycles", busy_cycles, 19);
    chk("tmo_no_early_flag", te_early, 0);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_no_done", done_count, 0);
    chk("tmo_result_kept", result, 8'h3C);
    chk("tmo_busy_low", busy, 0);
    rx_empty = 1'b0; r_data = 8'h5D;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tmo_cleared_by_start", timeout_err, 0);
    wait_done(1, lat);
    chk("tmo_next_result", result, 8'h5D);
`else
    busy_cycles = 0;
    te_early = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (busy) busy_cycles++;
      te_early = te_early | timeout_err;
      tick();
    end
    chk("notmo_still_busy", busy_cycles, 40);
    chk("notmo_no_flag", te_early, 0);
    chk("notmo_no_done", done_count, 0);
    chk("notmo_result_kept", result, 8'h3C);
    rx_empty = 1'b0; r_data = 8'h5D;
    wait_done(41, lat);
    chk("notmo_late_result", result, 8'h5D);
`endif

    chk("inv_wr_while_full", viol_full, 0);
    chk("inv_w_data_zero", viol_wdata, 0);
    chk("inv_rd_while_empty", viol_rd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 SHALL have parameter NBIT, default 8, data/byte width of operands, opcode and result.
REQ-002 SHALL have parameter TIMEOUT, default 1000000, clock cycles allowed between the last command byte write and the result byte read.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one command transaction.
REQ-006 SHALL have port op_a  input  NBIT  first operand.
REQ-007 SHALL have port op_b  input  NBIT  second operand.
REQ-008 SHALL have port opcode  input  NBIT  ALU operation code byte.
REQ-009 SHALL have port tx_full  input  1  UART TX FIFO full.
REQ-010 SHALL have port wr_uart  output  1  one-cycle TX FIFO write strobe.
REQ-011 SHALL have port w_data  output  NBIT  byte written to the TX FIFO.
REQ-012 SHALL have port rx_empty  input  1  UART RX FIFO empty.
REQ-013 SHALL have port r_data  input  NBIT  RX FIFO head byte, valid whenever rx_empty=0 (first-word fall-through).
REQ-014 SHALL have port rd_uart  output  1  one-cycle RX FIFO pop strobe.
REQ-015 SHALL have port result  output  NBIT  last received ALU result.
REQ-016 SHALL have port done  output  1  one-cycle pulse when result is updated.
REQ-017 SHALL have port busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-018 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement states IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE.
REQ-020 In IDLE, start=1 SHALL capture op_a/op_b/opcode into internal registers, clear timeout_err and go to SEND_A; later input changes SHALL NOT affect the transaction.
REQ-021 start while busy=1 SHALL be ignored (no queuing).
REQ-022 In SEND_A/SEND_B/SEND_OP, when tx_full=0, SHALL assert wr_uart for exactly one cycle with w_data = captured op_a/op_b/opcode respectively and advance to the next state; when tx_full=1, SHALL hold state with wr_uart=0.
REQ-023 Byte order on the wire SHALL always be op_a, op_b, opcode; each byte written exactly once.
REQ-024 SEND_OP SHALL go to WAIT_RES and clear the timeout counter in the cycle it writes.
REQ-025 In WAIT_RES, when rx_empty=0, SHALL assert rd_uart for one cycle, load result with r_data in that same edge, and go to DONE.
REQ-026 DONE SHALL assert done for one cycle and return to IDLE; start in DONE SHALL be ignored.
REQ-027 rd_uart SHALL never assert outside WAIT_RES; wr_uart SHALL never assert while tx_full=1.
REQ-028 w_data SHALL be 0 whenever wr_uart=0.
REQ-029 result SHALL hold its value between transactions and on timeout.
REQ-030 Minimum transaction latency with tx_full=0 and the result already present SHALL be 5 cycles from start-accept edge to done pulse.

Reset
REQ-031 RESET=0 SHALL immediately force state IDLE, wr_uart=0, rd_uart=0, w_data=0, result=0, done=0, busy=0, timeout_err=0, timeout counter 0, captured registers 0.
REQ-032 Reset mid-transaction SHALL abandon it; no further bytes written or read after release until a new start.

Configuration
REQ-033 With macro ALU_CMD_TIMEOUT_EN defined, WAIT_RES SHALL count cycles; on reaching TIMEOUT-1 with rx_empty=1 SHALL set timeout_err=1, leave result unchanged, not pulse done and return to IDLE.
REQ-034 Without ALU_CMD_TIMEOUT_EN, no counter SHALL be built, WAIT_RES SHALL wait indefinitely and timeout_err SHALL be constant 0.

Verification
REQ-035 op_a=0x05, op_b=0x03, opcode=0x20, tx_full=0, RX returns 0x08 -> wr_uart writes 0x05,0x03,0x20 in order, one rd_uart, result=0x08, one done pulse.
REQ-036 tx_full=1 for 10 cycles before op_b write -> no wr_uart during stall, op_b written once after release, sequence unchanged.
REQ-037 start pulsed again during SEND_B with different operands -> ignored; bytes match first capture.
REQ-038 RESET=0 asserted in WAIT_RES -> all outputs 0 asynchronously; RX byte arriving after release not popped.
REQ-039 ALU_CMD_TIMEOUT_EN, TIMEOUT=16, rx_empty held 1 -> timeout_err=1 after 16 WAIT_RES cycles, done=0, result unchanged, busy=0; next start clears timeout_err.
REQ-040 Result 0xFF already in RX FIFO at start -> done 5 cycles after start accept, result=0xFF.
